// File: rtl/lbist_pkg.sv
// Shared types and default constants for the logic-BIST controller.
// No logic; compile-time only.
// No flow control.
package lbist_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UNLOAD,
        ST_COMPARE,
        ST_DONE
    } lbist_state_e;

    // Feedback structure of the generic LFSR.
    typedef enum logic {
        FIBONACCI,
        GALOIS_MISR
    } lfsr_mode_e;

    // Polynomial masks: bit k-1 set for term x^k (x^16 implied by the MSB tap).
    // PRPG: x^16+x^14+x^13+x^11+1, taps on bits 15,13,12,10.
    localparam logic [15:0] PRPG_POLY_16 = 16'hB400;
    // MISR: x^16+x^15+x^13+x^4+1, lower terms folded in on MSB overflow.
    localparam logic [15:0] MISR_POLY_16 = 16'hA011;

    // Default PRPG start value; must be non-zero for a maximal-length sequence.
    localparam logic [15:0] PRPG_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/lbist_lfsr.sv
// Generic LFSR: Fibonacci pattern generator or Galois signature register.
// Latency: state updates on the clock edge after load_i/en_i.
// No backpressure; load_i overrides en_i, holds when neither is set.
module lbist_lfsr
    import lbist_pkg::*;
#(
    parameter int unsigned  W       = 16,
    parameter logic [W-1:0] POLY    = PRPG_POLY_16,
    parameter lfsr_mode_e   MODE    = FIBONACCI,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter int unsigned  OUT_W   = W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [W-1:0]     load_val_i,
    input  logic             en_i,
    input  logic [W-1:0]     par_i,
    output logic [OUT_W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    // Next state: parallel load, one LFSR step with the parallel input folded in, or hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (en_i) begin
            if (MODE == FIBONACCI) begin
                state_d = {state_q[W-2:0], ^(state_q & POLY)} ^ par_i;
            end else begin
                state_d = {state_q[W-2:0], 1'b0}
                        ^ (state_q[W-1] ? POLY : '0)
                        ^ par_i;
            end
        end
    end

    // State register with asynchronous return to the reset value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST controller: PRPG drives chain SI, FSM drives SE, MISR compacts SO.
// Latency: SE/busy rise the cycle after start; done after (PATTERNS+1)*CHAIN_LEN+PATTERNS+1 cycles.
// No backpressure; start is only honoured in IDLE/DONE and ignored while busy.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int unsigned       CHAINS    = 4,
    parameter int unsigned       CHAIN_LEN = 16,
    parameter int unsigned       PATTERNS  = 32,
    parameter int unsigned       PRPG_W    = 16,
    parameter int unsigned       MISR_W    = 16,
    parameter logic [PRPG_W-1:0] PRPG_SEED = PRPG_SEED_DEFAULT,
    parameter logic [PRPG_W-1:0] PRPG_POLY = PRPG_POLY_16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_POLY_16
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              start,
    input  logic [MISR_W-1:0] golden,
    input  logic [CHAINS-1:0] SO,
    output logic              SE,
    output logic [CHAINS-1:0] SI,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam int unsigned SC_W = $clog2(CHAIN_LEN);
    localparam int unsigned PC_W = $clog2(PATTERNS + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(CHAIN_LEN - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PATTERNS - 1);

    lbist_state_e    state_q, state_d;
    logic [SC_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [PC_W-1:0] pat_cnt_q, pat_cnt_d;
    logic            se_q, se_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            run_start;
    logic            misr_en;
    logic [MISR_W-1:0] misr_par;
    logic [MISR_W-1:0] misr_sig;

    // Sequencing: shift-type phases count CHAIN_LEN cycles, captures count patterns.
    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        run_start   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    run_start   = 1'b1;
                    shift_cnt_d = '0;
                    pat_cnt_d   = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            ST_LOAD, ST_SHIFT, ST_UNLOAD: begin
                if (shift_cnt_q == SC_LAST) begin
                    shift_cnt_d = '0;
                    if (state_q == ST_UNLOAD) begin
                        state_d = ST_COMPARE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    shift_cnt_d = shift_cnt_q + SC_W'(1);
                end
            end
            ST_CAPTURE: begin
                // The last capture's response goes out through UNLOAD instead of a SHIFT.
                pat_cnt_d = pat_cnt_q + PC_W'(1);
                if (pat_cnt_q == PC_LAST) begin
                    state_d = ST_UNLOAD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_COMPARE: begin
                pass_d  = (misr_sig == golden);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SE and busy are decoded from the next state so they leave a flop.
        se_d   = (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    // Controller state, counters and registered status outputs.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            pat_cnt_q   <= '0;
            se_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            se_q        <= se_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // LOAD shifts out whatever the chains held before the run, so only
    // SHIFT and UNLOAD cycles feed the MISR.
    always_comb begin
        misr_en              = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
        misr_par             = '0;
        misr_par[CHAINS-1:0] = SO;
    end

    // Pattern generator: steps whenever the chains shift, restarts from the seed per run.
    lbist_lfsr #(
        .W       (PRPG_W),
        .POLY    (PRPG_POLY),
        .MODE    (FIBONACCI),
        .RST_VAL (PRPG_SEED),
        .OUT_W   (CHAINS)
    ) u_prpg (
        .clk_i      (CK),
        .rst_ni     (RN),
        .load_i     (run_start),
        .load_val_i (PRPG_SEED),
        .en_i       (se_q),
        .par_i      ('0),
        .state_o    (SI)
    );

    // Signature register: compacts chain outputs, cleared per run.
    lbist_lfsr #(
        .W       (MISR_W),
        .POLY    (MISR_POLY),
        .MODE    (GALOIS_MISR),
        .RST_VAL ('0),
        .OUT_W   (MISR_W)
    ) u_misr (
        .clk_i      (CK),
        .rst_ni     (RN),
        .load_i     (run_start),
        .load_val_i ('0),
        .en_i       (misr_en),
        .par_i      (misr_par),
        .state_o    (misr_sig)
    );

    assign SE        = se_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_sig;

endmodule

// File: tb/tb_lbist_ctrl.sv
module tb_lbist_ctrl;

    localparam int S_LEN   = 4;
    localparam int S_PAT   = 2;
    localparam int F_LEN   = 16;
    localparam int F_PAT   = 32;
    localparam int F_TOTAL = (F_PAT + 1) * F_LEN + F_PAT + 1;

    localparam int PH_LOAD    = 0;
    localparam int PH_CAP     = 1;
    localparam int PH_SHIFT   = 2;
    localparam int PH_UNLOAD  = 3;
    localparam int PH_COMPARE = 4;

    logic        CK = 1'b0;
    logic        RN;

    logic        start_s, start_f;
    logic [15:0] golden_s, golden_f;
    logic [3:0]  so_s, so_f;
    logic        se_s, se_f;
    logic [3:0]  si_s, si_f;
    logic        busy_s, busy_f, done_s, done_f, pass_s, pass_f;
    logic [15:0] sig_s, sig_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CK = ~CK;

    lbist_ctrl #(.CHAINS(4), .CHAIN_LEN(S_LEN), .PATTERNS(S_PAT)) dut_s (
        .CK(CK), .RN(RN), .start(start_s), .golden(golden_s), .SO(so_s),
        .SE(se_s), .SI(si_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .signature(sig_s)
    );

    lbist_ctrl #(.CHAINS(4), .CHAIN_LEN(F_LEN), .PATTERNS(F_PAT)) dut_f (
        .CK(CK), .RN(RN), .start(start_f), .golden(golden_f), .SO(so_f),
        .SE(se_f), .SI(si_f), .busy(busy_f), .done(done_f), .pass(pass_f),
        .signature(sig_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // Reference PRPG: left-shifting Fibonacci, taps x^16, x^14, x^13, x^11.
    function automatic logic [15:0] prpg_next(input logic [15:0] p);
        return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
    endfunction

    // Reference MISR step.
    function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [3:0] so);
        logic [15:0] n;
        n = {m[14:0], 1'b0};
        if (m[15]) n = n ^ 16'hA011;
        return n ^ {12'h000, so};
    endfunction

    // Expected phase of the large instance in cycle k after the start edge.
    function automatic int phase_of(input int k);
        int t, blk, off;
        t = k - 1;
        if (t < F_LEN) return PH_LOAD;
        t = t - F_LEN;
        if (t >= F_PAT * (F_LEN + 1)) return PH_COMPARE;
        blk = t / (F_LEN + 1);
        off = t % (F_LEN + 1);
        if (off == 0) return PH_CAP;
        return (blk < F_PAT - 1) ? PH_SHIFT : PH_UNLOAD;
    endfunction

    // One full run of the 4x16 instance against a bench-side chain/circuit model.
    task automatic run_full(input bit inject, output logic [15:0] exp_sig, output int si_err);
        logic [15:0] p, m;
        logic [15:0] ch [4];
        logic [15:0] nch [4];
        logic [3:0]  so_now, so_drv;
        bit          injected;
        int          ph;
        p = 16'hACE1;
        m = 16'h0000;
        injected = 1'b0;
        si_err = 0;
        for (int c = 0; c < 4; c++) ch[c] = 16'($urandom);
        golden_f = 16'($urandom);
        start_f = 1'b1;
        step();
        start_f = 1'b0;
        for (int k = 1; k <= F_TOTAL; k++) begin
            ph = phase_of(k);
            so_now = {ch[3][15], ch[2][15], ch[1][15], ch[0][15]};
            so_drv = so_now;
            if (inject && !injected && ph == PH_SHIFT && so_now != 4'hF) begin
                for (int c = 0; c < 4; c++) begin
                    if (!injected && !so_now[c]) begin
                        so_drv[c] = 1'b1;
                        injected = 1'b1;
                    end
                end
            end
            so_f = so_drv;
            if (ph == PH_COMPARE) golden_f = m;
            if (ph == PH_LOAD || ph == PH_SHIFT || ph == PH_UNLOAD) begin
                if (si_f !== p[3:0]) si_err++;
            end
            step();
            if (ph == PH_SHIFT || ph == PH_UNLOAD) m = misr_next(m, so_now);
            if (ph == PH_LOAD || ph == PH_SHIFT || ph == PH_UNLOAD) begin
                for (int c = 0; c < 4; c++) ch[c] = {ch[c][14:0], p[c]};
                p = prpg_next(p);
            end else if (ph == PH_CAP) begin
                for (int c = 0; c < 4; c++)
                    nch[c] = ch[c] ^ {ch[(c + 1) % 4][14:0], ch[(c + 3) % 4][15]};
                for (int c = 0; c < 4; c++) ch[c] = nch[c];
            end
        end
        so_f = 4'h0;
        exp_sig = m;
    endtask

    initial begin
        logic [15:0] p;
        logic [15:0] sig_ok, sig_model2;
        logic        exp_se;
        int          cyc;
        int          si_err;

        // Reset held with random inputs.
        RN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_s = 1'($urandom); golden_s = 16'($urandom); so_s = 4'($urandom);
            start_f = 1'($urandom); golden_f = 16'($urandom); so_f = 4'($urandom);
            step();
        end
        chk("rst_se", se_s, 0);
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        chk("rst_pass", pass_s, 0);
        chk("rst_sig", sig_s, 16'h0000);
        chk("rst_si", si_s, 4'h1);
        chk("rst_sig_f", sig_f, 16'h0000);
        chk("rst_si_f", si_f, 4'h1);
        start_s = 1'b0; golden_s = 16'h0000; so_s = 4'h0;
        start_f = 1'b0; golden_f = 16'h0000; so_f = 4'h0;
        @(negedge CK);
        RN = 1'b1;
        step();

        // Sequencing, PRPG sequence and zero signature on the 4x4, 2-pattern instance.
        p = 16'hACE1;
        start_s = 1'b1;
        chk("seq_se_c0", se_s, 0);
        chk("seq_busy_c0", busy_s, 0);
        step();
        start_s = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            exp_se = (k >= 1 && k <= 4) || (k >= 6 && k <= 9) || (k >= 11 && k <= 14);
            chk($sformatf("seq_se_c%0d", k), se_s, exp_se);
            chk($sformatf("seq_busy_c%0d", k), busy_s, (k <= 15));
            chk($sformatf("seq_done_c%0d", k), done_s, (k == 16));
            if (k <= 9) chk($sformatf("si_c%0d", k), si_s, p[3:0]);
            if (k == 2) chk("si_hand_c2", si_s, 4'h3);
            if (k == 3) chk("si_hand_c3", si_s, 4'h7);
            if (exp_se) p = prpg_next(p);
            step();
        end
        chk("zero_sig", sig_s, 16'h0000);
        chk("zero_pass", pass_s, 1);
        chk("done_hold", done_s, 1);

        // start pulsed mid-run must not disturb the run length.
        start_s = 1'b1;
        step();
        cyc = 1;
        while (!done_s && cyc < 100) begin
            start_s = (cyc == 7);
            step();
            cyc++;
        end
        start_s = 1'b0;
        chk("pulse_len", cyc, 16);

        // start held high: restart straight out of DONE.
        start_s = 1'b1;
        step();
        cyc = 1;
        while (!done_s && cyc < 100) begin
            step();
            cyc++;
        end
        chk("held_len", cyc, 16);
        chk("held_pass", pass_s, 1);
        so_s = 4'hF;
        step();
        chk("held_restart_busy", busy_s, 1);
        chk("held_restart_done", done_s, 0);
        chk("held_restart_pass", pass_s, 0);
        chk("held_restart_se", se_s, 1);
        start_s = 1'b0;
        repeat (5) step();
        chk("load_masked_sig", sig_s, 16'h0000);
        repeat (2) step();
        chk("misr_hand_sig", sig_s, 16'h0011);

        // Asynchronous reset in the middle of SHIFT.
        #2;
        RN = 1'b0;
        #1;
        chk("mid_rst_se", se_s, 0);
        chk("mid_rst_busy", busy_s, 0);
        chk("mid_rst_done", done_s, 0);
        chk("mid_rst_pass", pass_s, 0);
        chk("mid_rst_sig", sig_s, 16'h0000);
        chk("mid_rst_si", si_s, 4'h1);
        step();
        step();
        so_s = 4'h0;
        golden_s = 16'h0000;
        @(negedge CK);
        RN = 1'b1;
        step();

        // Normal run after the reset.
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        cyc = 1;
        while (!done_s && cyc < 100) begin
            step();
            cyc++;
        end
        chk("rerun_len", cyc, 16);
        chk("rerun_pass", pass_s, 1);
        chk("rerun_sig", sig_s, 16'h0000);

        // Fault-free and single-fault runs on the 4x16 instance.
        run_full(1'b0, sig_ok, si_err);
        chk("f_sig_model", sig_f, sig_ok);
        chk("f_pass_clean", pass_f, 1);
        chk("f_done_clean", done_f, 1);
        chk("f_busy_clean", busy_f, 0);
        chk("f_si_track", si_err, 0);
        run_full(1'b1, sig_model2, si_err);
        chk("f_sig_differs", (sig_f != sig_ok), 1);
        chk("f_pass_fault", pass_f, 0);
        chk("f_done_fault", done_f, 1);
        chk("f_si_track2", si_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
